// File: rtl/mem_burst_responder.sv
// -----------------------------------------------------------------------------
// mem_burst_responder
//
// Backing memory model for the cache subsystem. Serves one request at a time:
//   - write: stores one 16-bit word in the same cycle it is accepted; the
//            responder stays ready, so back-to-back writes run one per cycle.
//   - read : after LATENCY cycles, streams the eight words of the addressed
//            16-byte block, one per cycle, each marked by rd_valid.
//
// Parameters
//   LATENCY   cycles from read acceptance to the first valid word (>= 1)
//   MEM_WORDS array depth in 16-bit words, indexed by req_addr[15:1]
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset (control state and outputs only)
//   req_valid  request present this cycle
//   req_write  1 = single-word write, 0 = block read
//   req_addr   byte address
//   req_wdata  write data
//   req_ready  high when a request can be accepted (IDLE)
//   busy       high while a read burst is in progress
//   rd_valid   rd_data carries a valid block word this cycle
//   rd_data    returned word (zero outside a burst)
//   rd_word    index 0..7 of the word on rd_data (zero outside a burst)
// -----------------------------------------------------------------------------
module mem_burst_responder #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        busy,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic [2:0]  rd_word
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // The WAIT countdown starts at LATENCY-2 so that WAIT lasts LATENCY-1
    // cycles; the width only needs to hold that start value.
    localparam int              CNT_W      = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int              CNT_INIT_I = (LATENCY >= 2) ? (LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(CNT_INIT_I);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [2:0]       word_reg,  word_next;
    logic [11:0]      base_reg,  base_next;

    logic [15:0] mem [MEM_WORDS];
    logic        wr_en;
    logic [14:0] rd_index;
    logic        in_stream;

    // Byte-lane bit of the address has no meaning for 16-bit words.
    logic unused_addr_bit;
    assign unused_addr_bit = req_addr[0];

    assign req_ready = (state_reg == ST_IDLE);
    assign in_stream = (state_reg == ST_STREAM);
    assign busy      = (state_reg == ST_WAIT) || in_stream;

    // rst_n gates the write so a request held during reset never lands,
    // even though req_ready reads high while reset is asserted.
    assign wr_en = req_valid && req_write && req_ready && rst_n;

    // Word counter sits below the base, so a burst never leaves its block.
    assign rd_index = {base_reg, word_reg};

    assign rd_valid = in_stream;
    assign rd_data  = in_stream ? mem[rd_index] : 16'h0000;
    assign rd_word  = in_stream ? word_reg : 3'b000;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        word_next  = word_reg;
        base_next  = base_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid && !req_write) begin
                    base_next  = req_addr[15:4];
                    word_next  = 3'd0;
                    count_next = CNT_INIT;
                    state_next = (LATENCY == 1) ? ST_STREAM : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_reg == '0) begin
                    state_next = ST_STREAM;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            ST_STREAM: begin
                // Wraps to 0 after word 7; the value is reloaded on the next accept.
                word_next = word_reg + 3'd1;
                if (word_reg == 3'd7) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            word_reg  <= 3'd0;
            base_reg  <= 12'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            word_reg  <= word_next;
            base_reg  <= base_next;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[req_addr[15:1]] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_responder
//
// Directed bench for mem_burst_responder. Instance dut_a uses LATENCY = 4,
// dut_b uses LATENCY = 1. Inputs change and outputs are sampled 1 time unit
// after each rising edge; "cycle N" below means the period after edge N.
// -----------------------------------------------------------------------------
module tb_mem_burst_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, busy, rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  rd_word;

    logic        b_req_valid, b_req_write;
    logic [15:0] b_req_addr, b_req_wdata;
    logic        b_req_ready, b_busy, b_rd_valid;
    logic [15:0] b_rd_data;
    logic [2:0]  b_rd_word;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_a0 [8];
    logic [15:0] exp_55 [8];

    always #5 clk = ~clk;

    mem_burst_responder #(.LATENCY(4), .MEM_WORDS(32768)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .busy      (busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_word   (rd_word)
    );

    mem_burst_responder #(.LATENCY(1), .MEM_WORDS(32768)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_req_valid),
        .req_write (b_req_write),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .req_ready (b_req_ready),
        .busy      (b_busy),
        .rd_valid  (b_rd_valid),
        .rd_data   (b_rd_data),
        .rd_word   (b_rd_word)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [15:0] addr, input logic [15:0] data);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        chk("wr_ready", {15'd0, req_ready}, 16'd1);
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
        $display("A write addr=%h data=%h", addr, data);
    endtask

    task automatic b_write(input logic [15:0] addr, input logic [15:0] data);
        b_req_valid = 1'b1;
        b_req_write = 1'b1;
        b_req_addr  = addr;
        b_req_wdata = data;
        step();
        b_req_valid = 1'b0;
        b_req_write = 1'b0;
        $display("B write addr=%h data=%h", addr, data);
    endtask

    // Full LATENCY=4 read: accept in cycle 0, WAIT cycles 1..3,
    // STREAM cycles 4..11, idle again in cycle 12.
    task automatic a_read_burst(input string tag, input logic [15:0] addr,
                                input logic [15:0] exp [8]);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_wdata = 16'h5A5A;
        chk({tag, "_ready_c0"}, {15'd0, req_ready}, 16'd1);
        step();
        req_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            chk({tag, "_wait_busy"},  {15'd0, busy},      16'd1);
            chk({tag, "_wait_valid"}, {15'd0, rd_valid},  16'd0);
            chk({tag, "_wait_ready"}, {15'd0, req_ready}, 16'd0);
            chk({tag, "_wait_data"},  rd_data,            16'h0000);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_valid"}, {15'd0, rd_valid},  16'd1);
            chk({tag, "_busy"},  {15'd0, busy},      16'd1);
            chk({tag, "_word"},  {13'd0, rd_word},   16'(k));
            chk({tag, "_data"},  rd_data,            exp[k]);
            step();
        end
        chk({tag, "_end_valid"}, {15'd0, rd_valid},  16'd0);
        chk({tag, "_end_busy"},  {15'd0, busy},      16'd0);
        chk({tag, "_end_ready"}, {15'd0, req_ready}, 16'd1);
        chk({tag, "_end_word"},  {13'd0, rd_word},   16'd0);
        $display("A read burst %s addr=%h", tag, addr);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            exp_a0[i] = 16'hA0A0 + 16'(i);
            exp_55[i] = 16'h5500 + 16'(i);
        end

        // ---- Power-up reset with a write request pending (must not land later)
        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_addr    = 16'h4002;
        req_wdata   = 16'hDEAD;
        b_req_valid = 1'b0;
        b_req_write = 1'b0;
        b_req_addr  = 16'h0000;
        b_req_wdata = 16'h0000;
        #1;
        chk("rst_ready", {15'd0, req_ready}, 16'd1);
        chk("rst_busy",  {15'd0, busy},      16'd0);
        chk("rst_valid", {15'd0, rd_valid},  16'd0);
        chk("rst_data",  rd_data,            16'h0000);
        chk("rst_word",  {13'd0, rd_word},   16'd0);
        step();
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
        rst_n     = 1'b1;
        step();
        $display("reset released");

        // ---- Fill memory
        for (int i = 0; i < 8; i++) a_write(16'h1000 + 16'(2 * i), 16'hA0A0 + 16'(i));
        for (int i = 0; i < 8; i++) a_write(16'h4000 + 16'(2 * i), 16'h5500 + 16'(i));
        for (int i = 0; i < 8; i++) a_write(16'h3000 + 16'(2 * i), 16'h3300 + 16'(i));
        for (int i = 0; i < 8; i++) b_write(16'h6000 + 16'(2 * i), 16'h6600 + 16'(i));

        // ---- Fill and burst: low address bits ignored, block 0x1000 returned
        a_read_burst("fill", 16'h100A, exp_a0);

        // ---- Request during busy: read 0x1000, then hold read 0x3000 from cycle 2
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h1000;
        step();                                   // cycle 1
        req_valid = 1'b0;
        step();                                   // cycle 2
        req_valid = 1'b1;
        req_addr  = 16'h3000;
        for (int c = 2; c <= 12; c++) begin
            chk("hold_ready", {15'd0, req_ready}, (c == 12) ? 16'd1 : 16'd0);
            chk("hold_valid", {15'd0, rd_valid},  (c >= 4 && c <= 11) ? 16'd1 : 16'd0);
            step();
        end
        req_valid = 1'b0;                         // cycle 13
        for (int c = 13; c <= 15; c++) begin
            chk("hold2_busy",  {15'd0, busy},     16'd1);
            chk("hold2_valid", {15'd0, rd_valid}, 16'd0);
            step();
        end
        chk("hold2_first_valid", {15'd0, rd_valid}, 16'd1);   // cycle 16
        chk("hold2_first_word",  {13'd0, rd_word},  16'd0);
        chk("hold2_first_data",  rd_data,           16'h3300);
        for (int c = 16; c < 24; c++) step();
        chk("hold2_end_ready", {15'd0, req_ready}, 16'd1);    // cycle 24
        $display("A read held during busy addr=3000");

        // ---- Write-then-read hazard
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h2002;
        req_wdata = 16'hBEEF;
        step();                                   // cycle 1
        req_write = 1'b0;
        req_addr  = 16'h2000;
        step();                                   // cycle 2
        req_valid = 1'b0;
        for (int c = 2; c < 6; c++) step();       // cycle 6
        chk("haz_valid", {15'd0, rd_valid}, 16'd1);
        chk("haz_word",  {13'd0, rd_word},  16'd1);
        chk("haz_data",  rd_data,           16'hBEEF);
        for (int c = 6; c < 13; c++) step();      // cycle 13
        chk("haz_end_ready", {15'd0, req_ready}, 16'd1);
        $display("A write-then-read hazard addr=2002");

        // ---- Reset mid-burst, with a write held during reset
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h1000;
        step();                                   // cycle 1
        req_valid = 1'b0;
        for (int c = 1; c < 7; c++) step();       // cycle 7
        chk("mid_word3", {13'd0, rd_word}, 16'd3);
        chk("mid_data3", rd_data,          16'hA0A3);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h4002;
        req_wdata = 16'hDEAD;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, rd_valid},  16'd0);
        chk("mid_rst_busy",  {15'd0, busy},      16'd0);
        chk("mid_rst_data",  rd_data,            16'h0000);
        chk("mid_rst_ready", {15'd0, req_ready}, 16'd1);
        step();
        chk("mid_rst_valid2", {15'd0, rd_valid}, 16'd0);
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
        rst_n     = 1'b1;
        step();
        chk("mid_after_valid", {15'd0, rd_valid},  16'd0);
        chk("mid_after_ready", {15'd0, req_ready}, 16'd1);
        $display("A reset mid-burst");
        a_read_burst("post_rst", 16'h1000, exp_a0);
        a_read_burst("no_rst_wr", 16'h4000, exp_55);

        // ---- LATENCY = 1 instance: STREAM in cycles 1..8, no WAIT
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 16'h6004;
        chk("b_ready_c0", {15'd0, b_req_ready}, 16'd1);
        step();                                   // cycle 1
        b_req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("b_valid", {15'd0, b_rd_valid}, 16'd1);
            chk("b_busy",  {15'd0, b_busy},     16'd1);
            chk("b_word",  {13'd0, b_rd_word},  16'(k));
            chk("b_data",  b_rd_data,           16'h6600 + 16'(k));
            step();
        end
        chk("b_end_valid", {15'd0, b_rd_valid},  16'd0);   // cycle 9
        chk("b_end_ready", {15'd0, b_req_ready}, 16'd1);
        $display("B read burst addr=6004");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Memory-side responder for cache block fills and single-word write-through. Accepts one request at a time. A read streams the eight 16-bit words of the addressed 16-byte block after a fixed latency, one word per cycle, each marked with a data-valid strobe. That strobe is the one the cache fill FSM counts to advance its word index and to write its data and tag arrays. A write updates one word in a single cycle. The block is the backing memory model for the cache subsystem in simulation and integration.

## Interface
- LATENCY, 4, cycles from request acceptance to first valid word; legal range ≥1.
- MEM_WORDS, 32768, array depth in 16-bit words; indexed by req_addr[15:1].
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present this cycle
- req_write  input  1  1 = single-word write, 0 = block read
- req_addr  input  16  byte address
- req_wdata  input  16  write data
- req_ready  output  1  high when a request can be accepted
- busy  output  1  high while a read burst is in progress
- rd_valid  output  1  rd_data holds a valid block word this cycle
- rd_data  output  16  returned word
- rd_word  output  3  index (0–7) of the word on rd_data

## Operation
- States:
  - IDLE: req_ready = 1, busy = 0.
  - WAIT: latency countdown, busy = 1.
  - STREAM: busy = 1, rd_valid = 1.
- Acceptance happens at a rising edge where req_valid & req_ready = 1. When req_ready = 0, requests are ignored. The requester holds its request until it is accepted.
- Write accepted:
  - Writes mem[req_addr[15:1]] ← req_wdata at that edge.
  - State stays IDLE, so one write is possible per cycle.
  - req_addr[0] is ignored.
- Read accepted:
  - Latches base = req_addr[15:4] and clears the word counter to 0.
  - req_addr[3:0] and req_wdata are ignored.
  - Next state is WAIT with countdown = LATENCY−2 if LATENCY ≥ 2. If LATENCY = 1, next state is STREAM directly.
- WAIT: decrements each cycle. When the countdown reaches 0, the next state is STREAM.
- STREAM:
  - rd_data = mem[{base, word}] and rd_word = word.
  - The counter increments each cycle.
  - At word = 7, the next state is IDLE. The counter wraps to 0 and is not used again until the next accept.
- Outside STREAM: rd_valid = 0, rd_data = 16'h0000, rd_word = 3'b000.
- The array is not reset; contents are undefined until written. Reset affects only control state and outputs.
- Address arithmetic: the 3-bit word counter concatenated with the 12-bit base gives a 15-bit word index. The counter never carries into base, so the burst stays inside the block.

## Timing
- The acceptance edge ends cycle 0. WAIT occupies cycles 1..LATENCY−1. STREAM occupies cycles LATENCY..LATENCY+7, with rd_word = cycle − LATENCY.
- req_ready returns high in cycle LATENCY+8. A request held from earlier is accepted at the end of that cycle. There is no overlap of bursts.
- Write visibility: a write accepted at the end of cycle t is visible to a read accepted at the end of cycle t+1 or later.
- rd_data is a combinational read of the array gated by the STREAM state. It is stable for the whole cycle when rd_valid = 1.
- Reset values (while rst_n = 0, taking effect immediately and asynchronously):
  - state IDLE, countdown 0, counter 0, base 0
  - req_ready = 1, busy = 0, rd_valid = 0, rd_data = 0, rd_word = 0
- Reset mid-burst:
  - Output drop: rd_valid drops in the same cycle rst_n falls.
  - No resumption: remaining words are never returned.
  - After reset: the first request after rst_n rises behaves as from power-up.
- Requests during reset are not accepted.

## Test plan
- Reset: drive rst_n = 0 with req_valid = 1 → req_ready = 1, busy = 0, rd_valid = 0, rd_data = 0, rd_word = 0; no write occurs (verified by later readback).
- Fill and burst (LATENCY = 4):
  - Stimulus: write 0xA0A0+i to byte addresses 0x1000+2i for i = 0..7, then read at req_addr = 0x100A.
  - Required response: rd_valid high in cycles 4–11 only; rd_word = 0..7; rd_data = 0xA0A0..0xA0A7; busy high in cycles 1–11.
- Request during busy: hold req_valid with a read of 0x3000 from cycle 2 of a burst → ignored until cycle 12; accepted at the end of cycle 12; first word of 0x3000 appears in cycle 16.
- Reset mid-burst: assert rst_n = 0 while rd_word = 3 → rd_valid = 0 in the same cycle; words 4–7 are never seen; after release, a new read returns the correct 8 words.
- LATENCY = 1 build: read accepted in cycle 0 → rd_valid in cycles 1–8; WAIT never entered.
- Write-then-read hazard: write 0xBEEF to 0x2002 in cycle 0, read 0x2000 accepted in cycle 1 → rd_word = 1 carries 0xBEEF in cycle 6.
